// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding, BCD limits and BCD increment for stopwatch_ctrl
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int BCD_W = 8;

  localparam logic [BCD_W-1:0] CS_MAX  = 8'h99;
  localparam logic [BCD_W-1:0] SEC_MAX = 8'h59;
  localparam logic [BCD_W-1:0] MIN_MAX = 8'h59;

  // Two-digit BCD +1; callers handle the wrap at their own limit.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_key_debounce.sv
// rtl/stopwatch_ctrl_key_debounce.sv - key synchronizer and tick-based debouncer with press pulse
module key_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEB_MS = 20
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_key,
  output logic o_press
);

  localparam int DEB_W = (DEB_MS > 1) ? $clog2(DEB_MS + 1) : 1;

  logic [1:0]       r_sync;
  logic             r_stable;
  logic [DEB_W-1:0] r_cnt;
  logic             r_press;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync   <= 2'b11;
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_key};
      r_press <= 1'b0;
      if (r_sync[1] == r_stable) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        if (r_cnt == DEB_W'(DEB_MS - 1)) begin
          // Level accepted; only a 1->0 change is a press.
          r_stable <= r_sync[1];
          r_cnt    <= '0;
          r_press  <= ~r_sync[1];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch top: prescaler, key debounce, IDLE/RUN/PAUSE FSM, BCD mm:ss.cc
// Optional lap hold display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CNT_1KHZ  = 50000,
  parameter int DIV_100HZ = 10,
  parameter int DEB_MS    = 20
) (
  input  logic             clk_50mhz,
  input  logic             rst,
  input  logic             key_start_stop,
  input  logic             key_clear,
`ifdef STOPWATCH_LAP_EN
  input  logic             key_lap,
`endif
  output logic             tick_1khz,
  output logic             tick_100hz,
  output logic             running,
  output logic [BCD_W-1:0] cs_bcd,
  output logic [BCD_W-1:0] sec_bcd,
  output logic [BCD_W-1:0] min_bcd,
  output logic             overflow
);

  localparam int CNT1_W = (CNT_1KHZ > 1) ? $clog2(CNT_1KHZ) : 1;
  localparam int CNT2_W = (DIV_100HZ > 1) ? $clog2(DIV_100HZ) : 1;

  logic [CNT1_W-1:0] r_cnt1;
  logic [CNT2_W-1:0] r_cnt2;
  logic              w_tick1;
  logic              w_tick100;

  assign w_tick1   = (r_cnt1 == CNT1_W'(CNT_1KHZ - 1));
  assign w_tick100 = w_tick1 && (r_cnt2 == CNT2_W'(DIV_100HZ - 1));

  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) begin
      r_cnt1 <= '0;
      r_cnt2 <= '0;
    end else begin
      if (w_tick1) r_cnt1 <= '0;
      else         r_cnt1 <= r_cnt1 + 1'b1;
      if (w_tick1) begin
        if (r_cnt2 == CNT2_W'(DIV_100HZ - 1)) r_cnt2 <= '0;
        else                                  r_cnt2 <= r_cnt2 + 1'b1;
      end
    end
  end

  assign tick_1khz  = w_tick1;
  assign tick_100hz = w_tick100;

  logic w_ss;
  logic w_clr;

  key_debounce #(.DEB_MS(DEB_MS)) u_db_ss (
    .i_clk   (clk_50mhz),
    .i_rst_n (rst),
    .i_tick  (w_tick1),
    .i_key   (key_start_stop),
    .o_press (w_ss)
  );

  key_debounce #(.DEB_MS(DEB_MS)) u_db_clr (
    .i_clk   (clk_50mhz),
    .i_rst_n (rst),
    .i_tick  (w_tick1),
    .i_key   (key_clear),
    .o_press (w_clr)
  );

  state_t r_state;
  logic   r_running;
  logic   w_enter_idle;
  logic   w_count;

  assign w_enter_idle = w_clr && (r_state != ST_IDLE);
  assign w_count      = w_tick100 && (r_state == ST_RUN);

  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_running <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ss && !w_clr) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_clr) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end else if (w_ss) begin
            r_state   <= ST_PAUSE;
            r_running <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (w_clr) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end else if (w_ss) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign running = r_running;

  logic [BCD_W-1:0] r_cs, r_sec, r_min;
  logic             r_ovf;
  logic [BCD_W-1:0] w_cs_nxt, w_sec_nxt, w_min_nxt;
  logic             w_ovf_nxt;

  // Idle entry takes priority over a coincident 100 Hz increment.
  always_comb begin
    w_cs_nxt  = r_cs;
    w_sec_nxt = r_sec;
    w_min_nxt = r_min;
    w_ovf_nxt = r_ovf;
    if (w_enter_idle) begin
      w_cs_nxt  = '0;
      w_sec_nxt = '0;
      w_min_nxt = '0;
      w_ovf_nxt = 1'b0;
    end else if (w_count) begin
      if (r_cs == CS_MAX) begin
        w_cs_nxt = '0;
        if (r_sec == SEC_MAX) begin
          w_sec_nxt = '0;
          if (r_min == MIN_MAX) begin
            w_min_nxt = '0;
            w_ovf_nxt = 1'b1;
          end else begin
            w_min_nxt = bcd_inc(r_min);
          end
        end else begin
          w_sec_nxt = bcd_inc(r_sec);
        end
      end else begin
        w_cs_nxt = bcd_inc(r_cs);
      end
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) begin
      r_cs  <= '0;
      r_sec <= '0;
      r_min <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cs  <= w_cs_nxt;
      r_sec <= w_sec_nxt;
      r_min <= w_min_nxt;
      r_ovf <= w_ovf_nxt;
    end
  end

  assign overflow = r_ovf;

`ifdef STOPWATCH_LAP_EN
  logic             w_lap;
  logic             r_lap_hold;
  logic [BCD_W-1:0] r_lap_cs, r_lap_sec, r_lap_min;

  key_debounce #(.DEB_MS(DEB_MS)) u_db_lap (
    .i_clk   (clk_50mhz),
    .i_rst_n (rst),
    .i_tick  (w_tick1),
    .i_key   (key_lap),
    .o_press (w_lap)
  );

  always_ff @(posedge clk_50mhz or negedge rst) begin
    if (!rst) begin
      r_lap_hold <= 1'b0;
      r_lap_cs   <= '0;
      r_lap_sec  <= '0;
      r_lap_min  <= '0;
    end else if (w_enter_idle) begin
      r_lap_hold <= 1'b0;
    end else if (w_lap && (r_state == ST_RUN)) begin
      r_lap_hold <= ~r_lap_hold;
      r_lap_cs   <= r_cs;
      r_lap_sec  <= r_sec;
      r_lap_min  <= r_min;
    end
  end

  assign cs_bcd  = r_lap_hold ? r_lap_cs  : r_cs;
  assign sec_bcd = r_lap_hold ? r_lap_sec : r_sec;
  assign min_bcd = r_lap_hold ? r_lap_min : r_min;
`else
  assign cs_bcd  = r_cs;
  assign sec_bcd = r_sec;
  assign min_bcd = r_min;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl with an elapsed-centisecond model
module tb_stopwatch_ctrl;

  localparam int CNT    = 4;
  localparam int DIV    = 10;
  localparam int DEB    = 2;
  localparam int PER100 = CNT * DIV;
  localparam int WRAP   = 360000;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       k_ss = 1'b1;
  logic       k_clr = 1'b1;
  logic       t1, t100, run, ovf;
  logic [7:0] cs, sec, mn;
  logic [7:0] f_cs, f_sec, f_min;

  int total = 0;
  int bad = 0;

  // Model: edge count since reset release, elapsed centiseconds, sticky overflow, state.
  int m_k = 0;
  int m_n = 0;
  int m_ov = 0;
  int m_st = M_IDLE;
  int ss_at = -1;
  int clr_at = -1;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .CNT_1KHZ  (CNT),
    .DIV_100HZ (DIV),
    .DEB_MS    (DEB)
  ) dut (
    .clk_50mhz      (clk),
    .rst            (rst),
    .key_start_stop (k_ss),
    .key_clear      (k_clr),
    .tick_1khz      (t1),
    .tick_100hz     (t100),
    .running        (run),
    .cs_bcd         (cs),
    .sec_bcd        (sec),
    .min_bcd        (mn),
    .overflow       (ovf)
  );

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // A key held from edge k+1 is synced two edges later and accepted on the
  // DEB-th 1 kHz tick after that; the FSM acts one edge after the press pulse.
  function automatic int press_edge(input int k);
    int a;
    a = k + 3;
    while (a % CNT != 0) a++;
    return a + CNT * (DEB - 1) + 1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_k++;
      if (m_st == M_RUN && m_k % PER100 == 0) begin
        m_n++;
        if (m_n == WRAP) begin
          m_n = 0;
          m_ov = 1;
        end
      end
      if (m_k == clr_at) begin
        if (m_st != M_IDLE) begin
          m_st = M_IDLE;
          m_n = 0;
          m_ov = 0;
        end
      end else if (m_k == ss_at) begin
        m_st = (m_st == M_RUN) ? M_PAUSE : M_RUN;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("tick_1khz", int'(t1), int'(m_k % CNT == CNT - 1));
      chk("tick_100hz", int'(t100), int'(m_k % PER100 == PER100 - 1));
      chk("running", int'(run), int'(m_st == M_RUN));
      chk("cs_bcd", int'(cs), int'(to_bcd(m_n % 100)));
      chk("sec_bcd", int'(sec), int'(to_bcd((m_n / 100) % 60)));
      chk("min_bcd", int'(mn), int'(to_bcd(m_n / 6000)));
      chk("overflow", int'(ovf), m_ov);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input bit ss, input bit clr);
    int at;
    at = press_edge(m_k);
    if (ss) begin
      ss_at = at;
      k_ss = 1'b0;
    end
    if (clr) begin
      clr_at = at;
      k_clr = 1'b0;
    end
    step(12);
    k_ss = 1'b1;
    k_clr = 1'b1;
    step(16);
  endtask

  // Only used while paused, so neither side is counting during the forced edge.
  task automatic preset(input int mm, input int ss, input int cc);
    f_min = to_bcd(mm);
    f_sec = to_bcd(ss);
    f_cs  = to_bcd(cc);
    force dut.r_min = f_min;
    force dut.r_sec = f_sec;
    force dut.r_cs  = f_cs;
    m_n = mm * 6000 + ss * 100 + cc;
    step(1);
    release dut.r_min;
    release dut.r_sec;
    release dut.r_cs;
  endtask

  initial begin
    #500000;
    bad++;
    $display("FAIL timeout: got no finish expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int c1, c100, g;
    #3;
    chk("rst_running", int'(run), 0);
    chk("rst_tick_1khz", int'(t1), 0);
    chk("rst_tick_100hz", int'(t100), 0);
    chk("rst_cs", int'(cs), 0);
    chk("rst_sec", int'(sec), 0);
    chk("rst_min", int'(mn), 0);
    chk("rst_overflow", int'(ovf), 0);
    @(posedge clk);
    #2;
    rst = 1'b1;

    c1 = 0;
    c100 = 0;
    repeat (80) begin
      @(negedge clk);
      c1 += int'(t1);
      c100 += int'(t100);
    end
    chk("tick_1khz_count", c1, 20);
    chk("tick_100hz_count", c100, 2);
    @(posedge clk);
    #2;

    k_ss = 1'b0;
    step(4);
    k_ss = 1'b1;
    step(16);
    chk("bounce_running", int'(run), 0);

    press(1'b1, 1'b0);
    chk("start_running", int'(run), 1);
    step(400);
    chk("single_event_running", int'(run), 1);
    press(1'b1, 1'b0);
    chk("stop_running", int'(run), 0);

    preset(1, 0, 90);
    press(1'b1, 1'b0);
    g = 0;
    while (m_n != 6100 && g < 2000) begin
      step(1);
      g++;
    end
    chk("wait_6100", m_n, 6100);
    chk("c6100_min", int'(mn), 8'h01);
    chk("c6100_sec", int'(sec), 8'h01);
    chk("c6100_cs", int'(cs), 8'h00);
    chk("c6100_ovf", int'(ovf), 0);
    press(1'b1, 1'b0);
    chk("pause2_running", int'(run), 0);

    preset(59, 59, 95);
    press(1'b1, 1'b0);
    g = 0;
    while (m_ov == 0 && g < 2000) begin
      step(1);
      g++;
    end
    chk("wait_wrap", m_ov, 1);
    chk("wrap_min", int'(mn), 8'h00);
    chk("wrap_sec", int'(sec), 8'h00);
    chk("wrap_cs", int'(cs), 8'h00);
    chk("wrap_ovf", int'(ovf), 1);
    step(100);
    chk("wrap_ovf_sticky", int'(ovf), 1);
    press(1'b0, 1'b1);
    chk("clr_running", int'(run), 0);
    chk("clr_ovf", int'(ovf), 0);
    chk("clr_cs", int'(cs), 0);
    chk("clr_sec", int'(sec), 0);
    chk("clr_min", int'(mn), 0);

    press(1'b0, 1'b1);
    chk("idle_clr_running", int'(run), 0);

    press(1'b1, 1'b0);
    step(100);
    press(1'b1, 1'b0);
    chk("pause3_running", int'(run), 0);
    press(1'b1, 1'b1);
    chk("both_running", int'(run), 0);
    chk("both_cs", int'(cs), 0);
    chk("both_sec", int'(sec), 0);
    chk("both_min", int'(mn), 0);
    step(60);
    chk("both_still_idle", int'(run), 0);

    press(1'b1, 1'b0);
    step(150);
    chk("pre_reset_running", int'(run), 1);
    rst = 1'b0;
    #1;
    chk("async_rst_running", int'(run), 0);
    chk("async_rst_cs", int'(cs), 0);
    chk("async_rst_sec", int'(sec), 0);
    chk("async_rst_min", int'(mn), 0);
    chk("async_rst_tick_1khz", int'(t1), 0);
    chk("async_rst_ovf", int'(ovf), 0);
    m_k = 0;
    m_n = 0;
    m_ov = 0;
    m_st = M_IDLE;
    ss_at = -1;
    clr_at = -1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    step(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
